sha2_mem_engine: RTL
====================

# sha2_mem_engine

Parametrised SHA-2 (SHA-256 / SHA-224) hashing co-processor with a single-port word memory interface. It is the successor to the fixed `sha256` co-processor. Given a start pulse, it reads a byte message from memory and applies FIPS 180-4 padding in hardware. It then compresses the message one 512-bit block at a time, at a configurable number of rounds per clock, and writes the digest back to memory. It sits between the host/control logic and the shared dual-port SRAM (`dpsram`).

## Interface
- `ADDR_W`, 16: width of word addresses (`mem_addr`, `message_addr`, `output_addr`).
- `UNROLL`, 1: compression rounds per clock. Legal values are 1 and 2; any other value is an elaboration error.

- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `mode`  in  1: 0 = SHA-256 (8 output words), 1 = SHA-224 (7 output words); latched on start.
- `message_addr`  in  ADDR_W: word address of message byte 0; latched on start.
- `size`  in  32: message length in bytes; latched on start.
- `output_addr`  in  ADDR_W: word address of the first digest word; latched on start.
- `done`  out  1: one-cycle completion pulse.
- `busy`  out  1: high from the accepted start until the done cycle (inclusive).
- `mem_clk`  out  1: equals `clk`.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory word address.
- `mem_write_data`  out  32: write data.
- `mem_read_data`  in  32: read data; valid the cycle after the address is presented while `mem_we`=0.

## Operation
- **Byte order:** big-endian within a word; byte 0 of the message is bits [31:24] of the word at `message_addr`.
- **Block count:** N = (size+8)/64 + 1, using integer division. The data word count is D = ceil(size/4).
- **Global word index:** g = blk*16 + i, for i = 0..15.
- **Block word sourcing, per g:**
  - g < size/4: memory word.
  - g == size/4 and size%4 != 0: memory word with the bytes beyond the message zeroed, and 0x80 placed in the first free byte.
  - g == size/4 and size%4 == 0: 0x80000000.
  - Last block, i=14: size>>29.
  - Last block, i=15: size<<3 (mod 2^32).
  - Otherwise: 0.
- **Memory reads:** issued only for g < D. No address beyond `message_addr`+D-1 is ever read.
- **State machine:**
  - IDLE: go to LOAD when `start`=1. Latch inputs, load H0..H7 with the SHA-256 or SHA-224 IV according to `mode`, and set blk=0.
  - LOAD: 17 cycles. The address for word i is issued in cycle i (i = 0..15), and the word is captured in cycle i+1 into a 16-entry rolling W window.
  - COMPUTE: 64/UNROLL cycles. Perform UNROLL rounds per cycle with W[t] expanded on the fly. The working registers a..h start from H.
  - UPDATE: 1 cycle, H += {a..h} mod 2^32. If blk<N-1, increment blk and go to LOAD; otherwise go to WRITE.
  - WRITE: OUT_WORDS cycles (8 for SHA-256, 7 for SHA-224). Drive `mem_we`=1, `mem_addr`=`output_addr`+k, `mem_write_data`=Hk.
  - DONE: 1 cycle with `done`=1, then go to IDLE.
- **Arithmetic:** all additions are 32-bit, wrapping. Address arithmetic wraps modulo 2^ADDR_W.
- **start while not IDLE:** ignored; the latched parameters are unchanged.
- **reset at any time, including mid-LOAD/COMPUTE/WRITE:** next state is IDLE. No further memory writes occur, and a partially written digest is left as-is.
- **size = 0:** single block, word 0 = 0x80000000. No memory reads are issued.

## Timing
- **Values during reset and in IDLE:** `done`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
- **Cycle reference:** cycle 0 is the edge at which start is sampled in IDLE.
- **Done latency:** `done` is high exactly in cycle N*(18+64/UNROLL) + OUT_WORDS + 1.
  - Example, UNROLL=1, SHA-256, size=120 (N=3): done at cycle 3*82+9 = 255.
- **`mem_we` during LOAD:** 0 in every LOAD cycle, including cycles whose word is synthesized, where `mem_addr` is don't-care but stable.
- **Digest visibility:** all digest words are written no later than the cycle before `done`, so memory is valid when `done` is observed.
- **Back-to-back:** a new start may be accepted on the cycle after DONE.

## Test plan
- SHA-256, size=3, word 0 = 0x61626300 ("abc") -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at `output_addr`..+7; done at cycle 91 (UNROLL=1).
- SHA-256, size=0 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; zero memory reads observed.
- SHA-224 "abc" -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 at 7 words; `output_addr`+7 is not written.
- Rotating-seed message (seed 0x01234567), sizes 55/56/64/120/121, both UNROLL values -> matches the behavioural model; N = 1/2/2/3/3; done cycle matches the formula.
- Pulse start mid-COMPUTE with different inputs -> ignored, and the original digest is written. Assert reset mid-WRITE -> `mem_we` is 0 from the next cycle, no done, `busy`=0, and a subsequent start completes correctly.

Source files
------------

// File: rtl/sha2_mem_engine_if.sv
// rtl/sha2_mem_engine_if.sv - host control and word-memory port bundle for sha2_mem_engine
interface sha2_mem_engine_if #(
    parameter int ADDR_W = 16
) ();
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] message_addr;
    logic [31:0]       size;
    logic [ADDR_W-1:0] output_addr;
    logic              done;
    logic              busy;
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output start, mode, message_addr, size, output_addr, mem_read_data,
        input  done, busy, mem_clk, mem_we, mem_addr, mem_write_data
    );

    modport slave (
        input  start, mode, message_addr, size, output_addr, mem_read_data,
        output done, busy, mem_clk, mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/sha2_mem_engine.sv
// rtl/sha2_mem_engine.sv - SHA-256/224 engine: reads, pads, compresses and writes back a memory message
module sha2_mem_engine #(
    parameter int ADDR_W = 16,
    parameter int UNROLL = 1
) (
    input logic              clk,
    input logic              reset,
    sha2_mem_engine_if.slave bus
);
    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("sha2_mem_engine: UNROLL must be 1 or 2");
    end

    localparam int RND_LAST = 64 / UNROLL - 1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UPDATE, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [27:0]       blk_q, blk_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0]       size_q, size_d;
    logic [31:0]       h_q [8], h_d [8];
    logic [31:0]       work_q [8], work_d [8];
    logic [31:0]       w_q [16], w_d [16];

    logic [31:0] r_work [8];
    logic [31:0] r_w [16];
    logic [31:0] rnd_t1, rnd_t2, rnd_nw;
    logic [31:0] ld_word;

    // Index of the last block and number of words that actually come from memory.
    logic [32:0] n_last, d_words;
    logic [31:0] g_iss, g_cap;
    logic [3:0]  i_cap;
    logic        is_last, rd_issue;
    assign n_last   = ({1'b0, size_q} + 33'd8) >> 6;
    assign d_words  = ({1'b0, size_q} + 33'd3) >> 2;
    assign g_iss    = {blk_q, cnt_q[3:0]};
    assign i_cap    = cnt_q[3:0] - 4'd1;
    assign g_cap    = {blk_q, i_cap};
    assign is_last  = ({5'b0, blk_q} == n_last);
    assign rd_issue = (state_q == S_LOAD) && !cnt_q[4] && ({1'b0, g_iss} < d_words);

    // Word entering the schedule window: message data, the 0x80 pad byte, or the bit length.
    always_comb begin
        ld_word = 32'h0;
        if (g_cap < (size_q >> 2)) begin
            ld_word = bus.mem_read_data;
        end else if (g_cap == (size_q >> 2)) begin
            case (size_q[1:0])
                2'd0:    ld_word = 32'h8000_0000;
                2'd1:    ld_word = {bus.mem_read_data[31:24], 24'h80_0000};
                2'd2:    ld_word = {bus.mem_read_data[31:16], 16'h8000};
                default: ld_word = {bus.mem_read_data[31:8], 8'h80};
            endcase
        end else if (is_last && i_cap == 4'd14) begin
            ld_word = {29'h0, size_q[31:29]};
        end else if (is_last && i_cap == 4'd15) begin
            ld_word = {size_q[28:0], 3'b000};
        end
    end

    // UNROLL compression rounds; the window always holds W[t..t+15] with W[t] at entry 0.
    always_comb begin
        r_work = work_q;
        r_w    = w_q;
        rnd_t1 = 32'h0;
        rnd_t2 = 32'h0;
        rnd_nw = 32'h0;
        for (int u = 0; u < UNROLL; u++) begin
            rnd_t1 = r_work[7] + bsig1(r_work[4]) + ((r_work[4] & r_work[5]) ^ (~r_work[4] & r_work[6]))
                   + K[6'(int'(cnt_q) * UNROLL + u)] + r_w[0];
            rnd_t2 = bsig0(r_work[0]) + ((r_work[0] & r_work[1]) ^ (r_work[0] & r_work[2]) ^ (r_work[1] & r_work[2]));
            rnd_nw = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
            for (int j = 7; j > 0; j--) r_work[j] = r_work[j-1];
            r_work[4] = r_work[4] + rnd_t1;
            r_work[0] = rnd_t1 + rnd_t2;
            for (int j = 0; j < 15; j++) r_w[j] = r_w[j+1];
            r_w[15] = rnd_nw;
        end
    end

    // Sequencing: next state, counters and datapath register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        mode_d     = mode_q;
        msg_addr_d = msg_addr_q;
        out_addr_d = out_addr_q;
        size_d     = size_q;
        h_d        = h_q;
        work_d     = work_q;
        w_d        = w_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    cnt_d      = 7'd0;
                    blk_d      = 28'd0;
                    mode_d     = bus.mode;
                    msg_addr_d = bus.message_addr;
                    out_addr_d = bus.output_addr;
                    size_d     = bus.size;
                    h_d        = bus.mode ? IV224 : IV256;
                end
            end
            S_LOAD: begin
                if (cnt_q != 7'd0) begin
                    for (int j = 0; j < 15; j++) w_d[j] = w_q[j+1];
                    w_d[15] = ld_word;
                end
                if (cnt_q == 7'd16) begin
                    state_d = S_COMPUTE;
                    cnt_d   = 7'd0;
                    work_d  = h_q;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_COMPUTE: begin
                work_d = r_work;
                w_d    = r_w;
                if (cnt_q == 7'(RND_LAST)) begin
                    state_d = S_UPDATE;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_UPDATE: begin
                for (int j = 0; j < 8; j++) h_d[j] = h_q[j] + work_q[j];
                cnt_d = 7'd0;
                if (is_last) begin
                    state_d = S_WRITE;
                end else begin
                    blk_d   = blk_q + 28'd1;
                    state_d = S_LOAD;
                end
            end
            S_WRITE: begin
                if (cnt_q == (mode_q ? 7'd6 : 7'd7)) begin
                    state_d = S_DONE;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, returned to IDLE by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers; only meaningful once a job has been accepted.
    always_ff @(posedge clk) begin
        blk_q      <= blk_d;
        mode_q     <= mode_d;
        msg_addr_q <= msg_addr_d;
        out_addr_q <= out_addr_d;
        size_q     <= size_d;
        h_q        <= h_d;
        work_q     <= work_d;
        w_q        <= w_d;
    end

    // Outputs are forced quiet while reset is asserted so a mid-write reset stops writes at once.
    assign bus.mem_clk        = clk;
    assign bus.done           = !reset && (state_q == S_DONE);
    assign bus.busy           = !reset && (state_q != S_IDLE);
    assign bus.mem_we         = !reset && (state_q == S_WRITE);
    assign bus.mem_addr       = reset                  ? '0 :
                                (state_q == S_WRITE)   ? out_addr_q + ADDR_W'(cnt_q) :
                                rd_issue               ? msg_addr_q + ADDR_W'(g_iss) : '0;
    assign bus.mem_write_data = (!reset && state_q == S_WRITE) ? h_q[cnt_q[2:0]] : 32'h0;
endmodule
